tetris_game_ctrl: RTL and testbench

Game sequencer for the 16x16 LED-matrix Tetris datapath. It takes shapes from the shape generator through a request/valid handshake and moves the active piece under gravity and player input. It detects collisions, locks pieces into the settled board, clears full rows, and flags game over. Its `red_pixels`/`grn_pixels` outputs drive `LEDDriver` directly. It replaces ad-hoc falling/lock logic in the top level.

---
 rtl/tetris_game_ctrl.sv | 152 +++++++++++++++
 tb/tb_tetris_game_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_game_ctrl.sv
// Tetris game sequencer: spawn handshake, gravity, moves, lock, row clear, game over.
// Define TETRIS_LINE_CLEAR_EN to compile in the CLEAR state and lines_cleared counting.
module tetris_game_ctrl #(
    parameter int TICK_MAX  = 1526,
    parameter int SPAWN_COL = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              move_left,
    input  logic              move_right,
    input  logic              drop,
    input  logic [3:0][3:0]   shape,
    input  logic              shape_vld,
    output logic              shape_req,
    output logic [15:0][15:0] red_pixels,
    output logic [15:0][15:0] grn_pixels,
    output logic [7:0]        lines_cleared,
    output logic              game_over
);

    localparam int CW = (TICK_MAX < 2) ? 1 : $clog2(TICK_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SPAWN, S_SPAWN_CHK, S_FALL, S_LOCK, S_CLEAR, S_GAME_OVER
    } state_t;

    state_t            state;
    logic [15:0][15:0] board;
    logic [15:0][15:0] canvas;
    logic [3:0][3:0]   shape_q;
    logic [3:0]        piece_row;
    logic [3:0]        piece_col;
    logic [CW-1:0]     counter;
    logic              tick;
    logic              fit_spawn, fit_down, fit_left, fit_right;
`ifdef TETRIS_LINE_CLEAR_EN
    logic [3:0]        ptr;
    logic [7:0]        lines_q;
`endif

    // A column offset outside 0..12 or any occupied row below row 15 never fits.
    function automatic logic fits(input logic [15:0][15:0] brd, input logic [3:0][3:0] shp,
                                  input int r, input int c);
        logic ok;
        ok = 1'b1;
        if (c < 0 || c > 12) ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (shp[i] != 4'd0) begin
                if (r + i > 15) ok = 1'b0;
                else if (((16'(shp[i]) << c) & brd[4'(r + i)]) != 16'd0) ok = 1'b0;
            end
        end
        return ok;
    endfunction

    always_comb begin
        canvas = '0;
        for (int i = 0; i < 4; i++) begin
            if (int'(piece_row) + i <= 15)
                canvas[4'(int'(piece_row) + i)] = 16'(shape_q[i]) << piece_col;
        end
    end

    assign fit_spawn = fits(board, shape_q, 0, SPAWN_COL);
    assign fit_down  = fits(board, shape_q, int'(piece_row) + 1, int'(piece_col));
    assign fit_left  = fits(board, shape_q, int'(piece_row), int'(piece_col) + 1);
    assign fit_right = fits(board, shape_q, int'(piece_row), int'(piece_col) - 1);
    assign tick      = (counter == CW'(TICK_MAX)) || drop;

    assign shape_req  = (state == S_SPAWN);
    assign game_over  = (state == S_GAME_OVER);
    assign grn_pixels = (state == S_FALL) ? canvas : '0;
    assign red_pixels = board | grn_pixels;
`ifdef TETRIS_LINE_CLEAR_EN
    assign lines_cleared = lines_q;
`else
    assign lines_cleared = 8'd0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            board     <= '0;
            shape_q   <= '0;
            piece_row <= '0;
            piece_col <= 4'(SPAWN_COL);
            counter   <= '0;
`ifdef TETRIS_LINE_CLEAR_EN
            ptr       <= '0;
            lines_q   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (start) state <= S_SPAWN;
                S_SPAWN: begin
                    if (shape_vld) begin
                        shape_q   <= shape;
                        piece_row <= '0;
                        piece_col <= 4'(SPAWN_COL);
                        counter   <= '0;
                        state     <= S_SPAWN_CHK;
                    end
                end
                S_SPAWN_CHK: state <= fit_spawn ? S_FALL : S_GAME_OVER;
                // A tick owns the cycle; moves only act between gravity steps.
                S_FALL: begin
                    if (tick) begin
                        counter <= '0;
                        if (fit_down) piece_row <= piece_row + 4'd1;
                        else          state     <= S_LOCK;
                    end else begin
                        counter <= counter + 1'b1;
                        if (move_left) begin
                            if (fit_left) piece_col <= piece_col + 4'd1;
                        end else if (move_right) begin
                            if (fit_right) piece_col <= piece_col - 4'd1;
                        end
                    end
                end
                S_LOCK: begin
                    board <= board | canvas;
`ifdef TETRIS_LINE_CLEAR_EN
                    ptr   <= 4'd15;
                    state <= S_CLEAR;
`else
                    state <= S_SPAWN;
`endif
                end
`ifdef TETRIS_LINE_CLEAR_EN
                // Scan bottom-up; ptr stays put after a collapse to recheck the row that fell in.
                S_CLEAR: begin
                    if (board[ptr] == 16'hFFFF) begin
                        for (int k = 1; k < 16; k++) begin
                            if (k <= int'(ptr)) board[4'(k)] <= board[4'(k - 1)];
                        end
                        board[0] <= 16'd0;
                        lines_q  <= lines_q + 8'd1;
                    end else if (ptr == 4'd0) begin
                        state <= S_SPAWN;
                    end else begin
                        ptr <= ptr - 4'd1;
                    end
                end
`endif
                S_GAME_OVER: state <= S_GAME_OVER;
                default:     state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// Directed bench for tetris_game_ctrl (TICK_MAX=3); honours TETRIS_LINE_CLEAR_EN.
module tb_tetris_game_ctrl;

    typedef logic [15:0][15:0] frame_t;

    typedef struct {
        logic st, ml, mr, dr, vld;
        logic exp_req, exp_over;
        int   exp_row, exp_col;
    } vec_t;

    localparam logic [3:0][3:0] SQ    = 16'h0033;
    localparam logic [3:0][3:0] IBAR  = 16'h000F;

    logic            clk = 1'b0;
    logic            reset, start, move_left, move_right, drop, shape_vld;
    logic [3:0][3:0] shape;
    logic            shape_req, game_over;
    frame_t          red_pixels, grn_pixels;
    logic [7:0]      lines_cleared;

    int checks = 0;
    int passed = 0;

    tetris_game_ctrl #(.TICK_MAX(3), .SPAWN_COL(6)) dut (
        .clk(clk), .reset(reset), .start(start), .move_left(move_left),
        .move_right(move_right), .drop(drop), .shape(shape), .shape_vld(shape_vld),
        .shape_req(shape_req), .red_pixels(red_pixels), .grn_pixels(grn_pixels),
        .lines_cleared(lines_cleared), .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic frame_t canvasOf(input logic [3:0][3:0] shp, input int row, input int col);
        frame_t f;
        f = '0;
        if (row >= 0) begin
            for (int i = 0; i < 4; i++)
                if (row + i <= 15) f[4'(row + i)] = 16'(shp[i]) << col;
        end
        return f;
    endfunction

    task automatic applyStimulus(input logic st, input logic ml, input logic mr,
                                 input logic dr, input logic vld);
        start = st; move_left = ml; move_right = mr; drop = dr; shape_vld = vld;
        @(posedge clk);
        #1;
        start = 1'b0; move_left = 1'b0; move_right = 1'b0; drop = 1'b0; shape_vld = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic waitReq(output int lat);
        lat = 0;
        while (shape_req !== 1'b1 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (shape_req !== 1'b1) begin
            checks++;
            $display("[TB] FAIL shape_req timeout: got 0 expected 1");
        end
    endtask

    // Spawn shp, walk it to column target around gravity ticks, then drop it until it locks.
    task automatic placePiece(input logic [3:0][3:0] shp, input int target, output int lockLat);
        int lat, cnt, col, guard;
        waitReq(lat);
        shape = shp;
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        cnt = 0;
        col = 6;
        while (col != target) begin
            if (cnt == 3) begin
                applyStimulus(0, 0, 0, 0, 0);
                cnt = 0;
            end else if (col < target) begin
                applyStimulus(0, 1, 0, 0, 0);
                col++; cnt++;
            end else begin
                applyStimulus(0, 0, 1, 0, 0);
                col--; cnt++;
            end
        end
        guard = 0;
        while (grn_pixels != '0 && guard < 20) begin
            applyStimulus(0, 0, 0, 1, 0);
            guard++;
        end
        if (grn_pixels != '0) begin
            checks++;
            $display("[TB] FAIL lock timeout: got piece expected locked");
        end
        waitReq(lockLat);
    endtask

    initial begin
        vec_t   vecs[14];
        frame_t exp, cv;
        int     lat;

        // piece 1: spawn handshake, gravity every 4 cycles, move priority, drop+move
        vecs[0]  = '{1, 0, 0, 0, 0, 1, 0, -1, 0};
        vecs[1]  = '{0, 0, 0, 0, 1, 0, 0, -1, 0};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 6};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 6};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 6};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 6};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 1, 6};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 6};
        vecs[8]  = '{0, 1, 0, 1, 0, 0, 0, 2, 6};
        vecs[9]  = '{0, 1, 0, 0, 0, 0, 0, 2, 7};
        vecs[10] = '{0, 0, 1, 0, 0, 0, 0, 2, 6};
        vecs[11] = '{0, 1, 1, 0, 0, 0, 0, 2, 7};
        vecs[12] = '{0, 1, 0, 0, 0, 0, 0, 3, 7};
        vecs[13] = '{0, 0, 1, 0, 0, 0, 0, 3, 6};

        reset = 1'b1; start = 1'b0; move_left = 1'b0; move_right = 1'b0;
        drop = 1'b0; shape_vld = 1'b0; shape = SQ;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset shape_req", 256'(shape_req), 256'(0));
        checkOutput("reset game_over", 256'(game_over), 256'(0));
        checkOutput("reset red", red_pixels, '0);
        checkOutput("reset grn", grn_pixels, '0);
        checkOutput("reset lines", 256'(lines_cleared), 256'(0));

        for (int v = 0; v < 14; v++) begin
            applyStimulus(vecs[v].st, vecs[v].ml, vecs[v].mr, vecs[v].dr, vecs[v].vld);
            cv = canvasOf(SQ, vecs[v].exp_row, vecs[v].exp_col);
            checkOutput($sformatf("vec%0d req", v), 256'(shape_req), 256'(vecs[v].exp_req));
            checkOutput($sformatf("vec%0d over", v), 256'(game_over), 256'(vecs[v].exp_over));
            checkOutput($sformatf("vec%0d grn", v), grn_pixels, cv);
            checkOutput($sformatf("vec%0d red", v), red_pixels, cv);
        end
        for (int d = 0; d < 12 && grn_pixels != '0; d++) applyStimulus(0, 0, 0, 1, 0);
        checkOutput("p1 locked grn", grn_pixels, '0);
        waitReq(lat);
`ifdef TETRIS_LINE_CLEAR_EN
        checkOutput("p1 lock latency", 256'(lat), 256'(17));
`else
        checkOutput("p1 lock latency", 256'(lat), 256'(1));
`endif
        exp = '0; exp[14] = 16'h00C0; exp[15] = 16'h00C0;
        checkOutput("p1 board", red_pixels, exp);

        // piece 2: left wall stops the piece at column 12
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("p2 spawn grn", grn_pixels, canvasOf(SQ, 0, 6));
        repeat (10) applyStimulus(0, 1, 0, 0, 0);
        checkOutput("p2 wall grn", grn_pixels, canvasOf(SQ, 2, 12));
        checkOutput("p2 wall red", red_pixels, exp | canvasOf(SQ, 2, 12));
        for (int d = 0; d < 20 && grn_pixels != '0; d++) applyStimulus(0, 0, 0, 1, 0);
        waitReq(lat);
        exp[14] = 16'h30C0; exp[15] = 16'h30C0;
        checkOutput("p2 board", red_pixels, exp);

        // reset mid-spawn clears the board and returns to IDLE
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 1);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mid reset red", red_pixels, '0);
        checkOutput("mid reset req", 256'(shape_req), 256'(0));

        // obstacle and game over
        applyStimulus(1, 0, 0, 0, 0);
        repeat (2) placePiece(SQ, 6, lat);
        shape = SQ;
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        repeat (14) applyStimulus(0, 0, 0, 1, 0);
        checkOutput("obst before grn", grn_pixels, canvasOf(SQ, 14, 8));
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("obst refused grn", grn_pixels, canvasOf(SQ, 14, 8));
        applyStimulus(0, 0, 0, 1, 0);
        waitReq(lat);
        repeat (6) placePiece(SQ, 6, lat);
        exp = '0;
        for (int r = 0; r < 14; r++) exp[r] = 16'h00C0;
        exp[14] = 16'h03C0; exp[15] = 16'h03C0;
        checkOutput("stack board", red_pixels, exp);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("go chk over", 256'(game_over), 256'(0));
        checkOutput("go chk req", 256'(shape_req), 256'(0));
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("go over", 256'(game_over), 256'(1));
        checkOutput("go grn", grn_pixels, '0);
        checkOutput("go red", red_pixels, exp);
        applyStimulus(0, 1, 0, 1, 1);
        checkOutput("go hold over", 256'(game_over), 256'(1));
        checkOutput("go hold red", red_pixels, exp);
        checkOutput("go hold req", 256'(shape_req), 256'(0));
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        reset = 1'b0;
        checkOutput("go reset over", 256'(game_over), 256'(0));
        checkOutput("go reset red", red_pixels, '0);

        // line clear: fill row 15
        applyStimulus(1, 0, 0, 0, 0);
        placePiece(SQ, 6, lat);
        placePiece(SQ, 4, lat);
`ifdef TETRIS_LINE_CLEAR_EN
        checkOutput("no-clear latency", 256'(lat), 256'(17));
`else
        checkOutput("no-clear latency", 256'(lat), 256'(1));
`endif
        placePiece(IBAR, 0, lat);
        placePiece(IBAR, 8, lat);
        placePiece(IBAR, 12, lat);
        exp = '0;
`ifdef TETRIS_LINE_CLEAR_EN
        checkOutput("clear latency", 256'(lat), 256'(18));
        exp[15] = 16'h00F0;
        checkOutput("clear lines", 256'(lines_cleared), 256'(1));
`else
        checkOutput("clear latency", 256'(lat), 256'(1));
        exp[14] = 16'h00F0; exp[15] = 16'hFFFF;
        checkOutput("clear lines", 256'(lines_cleared), 256'(0));
`endif
        checkOutput("clear board", red_pixels, exp);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
